vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates 640x480@60 VGA timing from the 100 MHz board clock. It feeds hCount/vCount/bright to the object/colour controller and a once-per-N-frames move_tick used as the game-update enable. It also takes the controller's combinational rgb back and drives registered, blanked, sync-aligned colour and sync pins to the VGA connector.

Parameters:
DIV, 4, clk cycles per pixel (1..16); DIV=1 -> pix_en tied high after reset.
H_TOTAL, 800, pixels per line.
H_SYNC, 96, hSync low width (hCount 0..H_SYNC-1).
H_ACT_START, 144, first visible hCount.
H_ACT_END, 784, first non-visible hCount after active region.
V_TOTAL, 525, lines per frame.
V_SYNC, 2, vSync low width (vCount 0..V_SYNC-1).
V_ACT_START, 35, first visible vCount.
V_ACT_END, 515, first non-visible vCount after active region.
FRAME_DIV, 1, frames per move_tick (1..256).

Ports:
clk  in  1  100 MHz system clock.
rst  in  1  asynchronous, active-high reset.
pix_en  out  1  one-clk pulse every DIV clks; pixel strobe.
hCount  out  10  horizontal counter, 0..H_TOTAL-1.
vCount  out  10  vertical counter, 0..V_TOTAL-1.
hSync  out  1  combinational decode of hCount, active low.
vSync  out  1  combinational decode of vCount, active low.
bright  out  1  combinational; 1 inside active window.
move_tick  out  1  registered one-clk pulse at frame start every FRAME_DIV frames.
rgb_in  in  12  colour from controller for current hCount/vCount, {R,G,B} 4 bits each.
vga_r, vga_g, vga_b  out  4 each  registered colour pins.
vga_hs, vga_vs  out  1 each  registered sync pins, delayed to match colour.

Behaviour:
- Reset (async, rst=1): div_cnt=0, hCount=0, vCount=0, frame_cnt=0, move_tick=0, vga_r/g/b=0, vga_hs=1, vga_vs=1. hSync/vSync/bright follow the decodes (0,0,0 at count 0,0).
- Divider: div_cnt 0..DIV-1, increments each clk, wraps to 0. pix_en=1 iff div_cnt==DIV-1. First pix_en on the DIV-th rising edge after rst deasserts.
- Counters advance only on clk edges where pix_en=1:
  - hCount: +1; at H_TOTAL-1 -> 0.
  - vCount: +1 only when hCount wraps; at V_TOTAL-1 (with hCount wrap) -> 0.
- Decodes, all combinational from the current counters:
  - hSync = (hCount >= H_SYNC).
  - vSync = (vCount >= V_SYNC).
  - bright = H_ACT_START <= hCount < H_ACT_END and V_ACT_START <= vCount < V_ACT_END.
  - Defaults: visible region 144..783 x 35..514.
- Frame/tick:
  - On the pix_en edge where both counters wrap to (0,0):
    - if frame_cnt==FRAME_DIV-1: frame_cnt<=0, move_tick<=1;
    - else: frame_cnt+1, move_tick<=0.
  - All other edges: move_tick<=0. move_tick is exactly one clk wide, regardless of DIV.
- Output pipeline, on pix_en edges only (hold otherwise):
  - {vga_r,vga_g,vga_b} <= bright ? rgb_in : 12'h000.
  - vga_hs<=hSync, vga_vs<=vSync.
  - Latency: exactly one pixel from counter value to pins; colour and sync stay mutually aligned.
- rgb_in is sampled only on pix_en edges; it may change freely between strobes.
- Mid-operation reset: all state returns to reset values immediately, without waiting for a clk edge. After release, timing restarts from (0,0) with no partial move_tick.
- Widths: counters are 10 bits, frame_cnt is 8 bits; no overflow is possible for legal parameters.

Test Plan:
- Reset/strobe: hold rst 5 clks, release -> all outputs at reset values; pix_en high on clks 4, 8, 12… after release; hCount=1 after the first pix_en edge.
- Line timing: run one line -> hSync low for exactly 96 pixels (hCount 0..95); hCount 799 -> 0 with vCount 0 -> 1 on the same pix_en edge.
- Active window: sweep one frame -> bright=1 for exactly 640x480=307200 pix_en cycles; bright=0 at hCount=143/784 and vCount=34/515; 1 at (144,35) and (783,514).
- Frame/tick: FRAME_DIV=2, run 4 frames -> move_tick pulses twice, each 1 clk wide, 2x420000 pix_en apart; vSync low for exactly 1600 pixels per frame.
- Colour pipeline: rgb_in=12'hF00 constant -> vga_r=F, g=0, b=0 one pixel after bright rises, 0 one pixel after bright falls; vga_hs falls one pixel after hSync falls.
- Async reset mid-frame: assert rst at (400,200) between clk edges -> counters 0, vga_hs/vs=1, colour 0 before the next edge; after release, the first move_tick comes only at the next full frame wrap.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel timing, colour return path and VGA connector pins between
// the timing generator (master) and the object/colour controller (slave).
interface vga_timing_if;
    logic        pix_en;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSync;
    logic        vSync;
    logic        bright;
    logic        move_tick;
    logic [11:0] rgb_in;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;

    modport master (
        output pix_en, hCount, vCount, hSync, vSync, bright, move_tick,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs,
        input  rgb_in
    );

    modport slave (
        input  pix_en, hCount, vCount, hSync, vSync, bright, move_tick,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs,
        output rgb_in
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/counter generator with frame-rate move_tick and a
// one-pixel registered output stage for blanked colour and sync pins.
module vga_timing_gen #(
    parameter int DIV         = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter int FRAME_DIV   = 1
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master bus
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_W   = 10'(H_SYNC);
    localparam logic [9:0] VS_W   = 10'(V_SYNC);
    localparam logic [9:0] HA_S   = 10'(H_ACT_START);
    localparam logic [9:0] HA_E   = 10'(H_ACT_END);
    localparam logic [9:0] VA_S   = 10'(V_ACT_START);
    localparam logic [9:0] VA_E   = 10'(V_ACT_END);
    localparam logic [7:0] FD_LAST = 8'(FRAME_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          move_tick_q, move_tick_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          hs_q, vs_q;
    logic          pix_en, h_wrap, v_wrap, frame_wrap, h_sync, v_sync, bright;

    assign pix_en     = div_cnt_q == DIV_LAST;
    assign h_wrap     = h_cnt_q == H_LAST;
    assign v_wrap     = v_cnt_q == V_LAST;
    assign frame_wrap = h_wrap && v_wrap;
    assign h_sync     = h_cnt_q >= HS_W;
    assign v_sync     = v_cnt_q >= VS_W;
    assign bright     = (h_cnt_q >= HA_S) && (h_cnt_q < HA_E) &&
                        (v_cnt_q >= VA_S) && (v_cnt_q < VA_E);

    always_comb begin
        div_cnt_d   = pix_en ? '0 : div_cnt_q + DW'(1);
        h_cnt_d     = h_wrap ? '0 : h_cnt_q + 10'd1;
        v_cnt_d     = !h_wrap ? v_cnt_q : (v_wrap ? '0 : v_cnt_q + 10'd1);
        frame_cnt_d = !frame_wrap ? frame_cnt_q :
                      (frame_cnt_q == FD_LAST ? '0 : frame_cnt_q + 8'd1);
        // Tick is a plain clk-domain pulse so it stays one clk wide for any DIV.
        move_tick_d = pix_en && frame_wrap && (frame_cnt_q == FD_LAST);
        rgb_d       = bright ? bus.rgb_in : 12'h000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            move_tick_q <= 1'b0;
            rgb_q       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else begin
            div_cnt_q   <= div_cnt_d;
            move_tick_q <= move_tick_d;
            if (pix_en) begin
                h_cnt_q     <= h_cnt_d;
                v_cnt_q     <= v_cnt_d;
                frame_cnt_q <= frame_cnt_d;
                rgb_q       <= rgb_d;
                hs_q        <= h_sync;
                vs_q        <= v_sync;
            end
        end
    end

    assign bus.pix_en    = pix_en;
    assign bus.hCount    = h_cnt_q;
    assign bus.vCount    = v_cnt_q;
    assign bus.hSync     = h_sync;
    assign bus.vSync     = v_sync;
    assign bus.bright    = bright;
    assign bus.move_tick = move_tick_q;
    assign bus.vga_r     = rgb_q[11:8];
    assign bus.vga_g     = rgb_q[7:4];
    assign bus.vga_b     = rgb_q[3:0];
    assign bus.vga_hs    = hs_q;
    assign bus.vga_vs    = vs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: shrunken-geometry bench; an arithmetic pixel-index model
// predicts every output each cycle, with literal totals pinning the model.
module tb_vga_timing_gen;
    localparam int DIV = 2, HT = 20, HS = 3, HA = 5, HE = 17;
    localparam int VT = 12, VS = 2, VA = 3, VE = 10, FD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_if bus();

    vga_timing_gen #(
        .DIV(DIV), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA), .H_ACT_END(HE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA), .V_ACT_END(VE), .FRAME_DIV(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic visible(input int h, input int v);
        return (h >= HA) && (h < HE) && (v >= VA) && (v < VE);
    endfunction

    // Model: n = clk edges since reset release; pixel index = n / DIV.
    int          n = 0;
    logic [11:0] m_rgb = '0;
    logic        m_hs = 1'b1;
    logic        m_vs = 1'b1;
    int          mp, mh, mv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            m_rgb = '0;
            m_hs = 1'b1;
            m_vs = 1'b1;
        end else begin
            if ((n + 1) % DIV == 0) begin
                mp = n / DIV;
                mh = mp % HT;
                mv = (mp / HT) % VT;
                m_rgb = visible(mh, mv) ? bus.rgb_in : 12'h000;
                m_hs = mh >= HS;
                m_vs = mv >= VS;
            end
            n++;
        end
    end

    always @(negedge clk) bus.rgb_in = 12'($urandom);

    int   n_bright, n_hlow, n_vlow, n_tick;
    int   tick_n[$];
    logic bmap[0:VT-1][0:HT-1];
    int   cp, ch, cv;
    logic [63:0] exp_v, act_v;

    task automatic clear_stats();
        n_bright = 0;
        n_hlow = 0;
        n_vlow = 0;
        n_tick = 0;
        tick_n.delete();
    endtask

    always @(negedge clk) begin
        #1;
        cp = n / DIV;
        ch = cp % HT;
        cv = (cp / HT) % VT;
        exp_v = {25'd0, ((n + 1) % DIV == 0), 10'(ch), 10'(cv), ch >= HS, cv >= VS,
                 visible(ch, cv), (n % DIV == 0) && (cp > 0) && (cp % (HT * VT * FD) == 0),
                 m_rgb, m_hs, m_vs};
        act_v = {25'd0, bus.pix_en, bus.hCount, bus.vCount, bus.hSync, bus.vSync,
                 bus.bright, bus.move_tick, bus.vga_r, bus.vga_g, bus.vga_b,
                 bus.vga_hs, bus.vga_vs};
        check("cycle_outputs", act_v, exp_v);
        if (bus.pix_en && bus.bright) n_bright++;
        if (bus.pix_en && !bus.hSync) n_hlow++;
        if (bus.pix_en && !bus.vSync) n_vlow++;
        if (bus.move_tick) begin
            n_tick++;
            tick_n.push_back(n);
        end
        if (bus.pix_en && int'(bus.hCount) < HT && int'(bus.vCount) < VT)
            bmap[int'(bus.vCount)][int'(bus.hCount)] = bus.bright;
    end

    initial begin
        bus.rgb_in = '0;
        clear_stats();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        clear_stats();
        #2;
        check("rst_hcount", 64'(bus.hCount), 64'd0);
        check("rst_vcount", 64'(bus.vCount), 64'd0);
        check("rst_decodes", 64'({bus.hSync, bus.vSync, bus.bright, bus.pix_en}), 64'd0);
        check("rst_pins", 64'({bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs}), 64'h3);
        check("rst_tick", 64'(bus.move_tick), 64'd0);
        @(negedge clk); #2;
        check("first_strobe", 64'({bus.pix_en, bus.hCount}), 64'({1'b1, 10'd0}));
        @(negedge clk); #2;
        check("after_strobe", 64'({bus.pix_en, bus.hCount}), 64'({1'b0, 10'd1}));
        repeat (1918) @(negedge clk);
        #2;
        check("bright_count", 64'(n_bright), 64'd336);
        check("hsync_low_count", 64'(n_hlow), 64'd144);
        check("vsync_low_count", 64'(n_vlow), 64'd160);
        check("tick_count", 64'(n_tick), 64'd2);
        if (tick_n.size() == 2) begin
            check("tick_first", 64'(tick_n[0]), 64'd960);
            check("tick_spacing", 64'(tick_n[1] - tick_n[0]), 64'd960);
        end
        check("bright_h4_v3", 64'(bmap[3][4]), 64'd0);
        check("bright_h5_v3", 64'(bmap[3][5]), 64'd1);
        check("bright_h16_v9", 64'(bmap[9][16]), 64'd1);
        check("bright_h17_v9", 64'(bmap[9][17]), 64'd0);
        check("bright_h5_v2", 64'(bmap[2][5]), 64'd0);
        check("bright_h5_v10", 64'(bmap[10][5]), 64'd0);
        repeat (740) @(negedge clk);
        #2;
        check("pre_reset_pos", 64'({bus.hCount, bus.vCount}), 64'({10'd10, 10'd6}));
        #1 rst = 1'b1;
        #1;
        check("async_counters", 64'({bus.hCount, bus.vCount}), 64'd0);
        check("async_pins", 64'({bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs}), 64'h3);
        check("async_tick", 64'({bus.move_tick, bus.pix_en}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_stats();
        repeat (1920) @(negedge clk);
        #2;
        check("restart_tick_count", 64'(n_tick), 64'd2);
        if (tick_n.size() > 0) check("restart_tick_first", 64'(tick_n[0]), 64'd960);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
